fwd_operand_stage: RTL and testbench

FWD_OPERAND_STAGE -- requirements
Module: fwd_operand_stage

---
 rtl/fwd_pkg.sv | 19 +
 rtl/fwd_match.sv | 36 +++
 rtl/fwd_operand_stage.sv | 203 ++++++++++++++++++++
 tb/tb_fwd_operand_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand forwarding stage and its matcher.
package fwd_pkg;

  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  // Width of a source code able to represent 0 (register file) and 1..num_src.
  function automatic int sel_width(input int num_src);
    int w;
    w = $clog2(num_src + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority forwarding matcher: picks the youngest producer writing the
// requested address, else the register-file data. Address 0 never forwards.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int SEL_W   = sel_width(NUM_SRC)
) (
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic [DATA_W-1:0]         rf_data_i,
  input  logic [NUM_SRC-1:0]        prod_wr_i,
  input  logic [NUM_SRC*ADDR_W-1:0] prod_rd_i,
  input  logic [NUM_SRC*DATA_W-1:0] prod_data_i,
  input  logic [NUM_SRC-1:0]        prod_pend_i,
  output logic [DATA_W-1:0]         data_o,
  output logic [SEL_W-1:0]          code_o,
  output logic                      pend_o
);

  // Walk oldest to youngest so the lowest-index match is the last to assign.
  always_comb begin
    data_o = rf_data_i;
    code_o = '0;
    pend_o = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (prod_wr_i[k] && (prod_rd_i[k*ADDR_W +: ADDR_W] == addr_i) && (addr_i != '0)) begin
        data_o = prod_data_i[k*DATA_W +: DATA_W];
        code_o = SEL_W'(k + 1);
        pend_o = prod_pend_i[k];
      end
    end
  end

endmodule

// File: rtl/fwd_operand_stage.sv
// Operand resolve stage with producer forwarding and load-hazard stall.
// Optional statistics counters enabled by defining FWD_STATS_EN.
//
// state    | meaning
// ST_IDLE  | empty, ready for a request
// ST_WAIT  | request held, a winning producer is still pending
// ST_VALID | resolved operands presented downstream
module fwd_operand_stage
  import fwd_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  localparam int SEL_W  = sel_width(NUM_SRC)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [ADDR_W-1:0]         rs_addr_i,
  input  logic [ADDR_W-1:0]         rt_addr_i,
  input  logic [DATA_W-1:0]         rs_data_i,
  input  logic [DATA_W-1:0]         rt_data_i,
  input  logic [NUM_SRC-1:0]        prod_wr_i,
  input  logic [NUM_SRC*ADDR_W-1:0] prod_rd_i,
  input  logic [NUM_SRC*DATA_W-1:0] prod_data_i,
  input  logic [NUM_SRC-1:0]        prod_pend_i,
  input  logic                      flush_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_W-1:0]         op_a_o,
  output logic [DATA_W-1:0]         op_b_o,
  output logic [SEL_W-1:0]          fw_a_o,
  output logic [SEL_W-1:0]          fw_b_o,
  output logic                      stall_o
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]               fwd_cnt_o,
  output logic [31:0]               stall_cnt_o
`endif
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d;
  logic [DATA_W-1:0]  rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic [DATA_W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [SEL_W-1:0]   fw_a_q, fw_a_d, fw_b_q, fw_b_d;

  logic               accept;
  logic               hazard;
  logic               load_ops;
  logic [ADDR_W-1:0]  res_rs_addr, res_rt_addr;
  logic [DATA_W-1:0]  res_rs_data, res_rt_data;
  logic [DATA_W-1:0]  m_a_data, m_b_data;
  logic [SEL_W-1:0]   m_a_code, m_b_code;
  logic               m_a_pend, m_b_pend;

  // While waiting, resolve the held request; otherwise resolve the incoming one.
  always_comb begin
    res_rs_addr = rs_addr_i;
    res_rt_addr = rt_addr_i;
    res_rs_data = rs_data_i;
    res_rt_data = rt_data_i;
    if (state_q == ST_WAIT) begin
      res_rs_addr = rs_addr_q;
      res_rt_addr = rt_addr_q;
      res_rs_data = rs_data_q;
      res_rt_data = rt_data_q;
    end
  end

  fwd_match #(
    .DATA_W (DATA_W),
    .NUM_SRC(NUM_SRC),
    .ADDR_W (ADDR_W),
    .SEL_W  (SEL_W)
  ) u_match_a (
    .addr_i     (res_rs_addr),
    .rf_data_i  (res_rs_data),
    .prod_wr_i  (prod_wr_i),
    .prod_rd_i  (prod_rd_i),
    .prod_data_i(prod_data_i),
    .prod_pend_i(prod_pend_i),
    .data_o     (m_a_data),
    .code_o     (m_a_code),
    .pend_o     (m_a_pend)
  );

  fwd_match #(
    .DATA_W (DATA_W),
    .NUM_SRC(NUM_SRC),
    .ADDR_W (ADDR_W),
    .SEL_W  (SEL_W)
  ) u_match_b (
    .addr_i     (res_rt_addr),
    .rf_data_i  (res_rt_data),
    .prod_wr_i  (prod_wr_i),
    .prod_rd_i  (prod_rd_i),
    .prod_data_i(prod_data_i),
    .prod_pend_i(prod_pend_i),
    .data_o     (m_b_data),
    .code_o     (m_b_code),
    .pend_o     (m_b_pend)
  );

  assign hazard      = m_a_pend | m_b_pend;
  assign in_ready_o  = (state_q == ST_IDLE) || ((state_q == ST_VALID) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == ST_VALID);
  assign stall_o     = (state_q == ST_WAIT);
  assign op_a_o      = op_a_q;
  assign op_b_o      = op_b_q;
  assign fw_a_o      = fw_a_q;
  assign fw_b_o      = fw_b_q;

  always_comb begin
    state_d   = state_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    load_ops  = 1'b0;

    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_VALID: begin
          if (accept) begin
            rs_addr_d = rs_addr_i;
            rt_addr_d = rt_addr_i;
            rs_data_d = rs_data_i;
            rt_data_d = rt_data_i;
            state_d   = hazard ? ST_WAIT : ST_VALID;
            load_ops  = !hazard;
          end else if ((state_q == ST_VALID) && out_ready_i) begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!hazard) begin
            state_d  = ST_VALID;
            load_ops = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    op_a_d = load_ops ? m_a_data : op_a_q;
    op_b_d = load_ops ? m_b_data : op_b_q;
    fw_a_d = load_ops ? m_a_code : fw_a_q;
    fw_b_d = load_ops ? m_b_code : fw_b_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      fw_a_q    <= '0;
      fw_b_q    <= '0;
    end else begin
      state_q   <= state_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      fw_a_q    <= fw_a_d;
      fw_b_q    <= fw_b_d;
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] fwd_cnt_q, fwd_cnt_d, stall_cnt_q, stall_cnt_d;

  // A flushed WAIT cycle is discarded work, so it is not counted as a stall.
  always_comb begin
    fwd_cnt_d   = fwd_cnt_q + 32'(load_ops && ((m_a_code != '0) || (m_b_code != '0)));
    stall_cnt_d = stall_cnt_q + 32'((state_q == ST_WAIT) && !flush_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_cnt_o   = fwd_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Directed bench for fwd_operand_stage: vector table plus multi-cycle sequences.
module tb_fwd_operand_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [4:0]  rs_addr_i, rt_addr_i;
  logic [31:0] rs_data_i, rt_data_i;
  logic [1:0]  prod_wr_i, prod_pend_i;
  logic [4:0]  rd0, rd1;
  logic [31:0] d0, d1;
  logic [9:0]  prod_rd_i;
  logic [63:0] prod_data_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] op_a_o, op_b_o;
  logic [1:0]  fw_a_o, fw_b_o;
  logic        stall_o;
`ifdef FWD_STATS_EN
  logic [31:0] fwd_cnt_o, stall_cnt_o;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  assign prod_rd_i   = {rd1, rd0};
  assign prod_data_i = {d1, d0};

  always #5 clk_i = ~clk_i;

  fwd_operand_stage #(.DATA_W(32), .NUM_SRC(2), .ADDR_W(5)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .rs_addr_i  (rs_addr_i),
    .rt_addr_i  (rt_addr_i),
    .rs_data_i  (rs_data_i),
    .rt_data_i  (rt_data_i),
    .prod_wr_i  (prod_wr_i),
    .prod_rd_i  (prod_rd_i),
    .prod_data_i(prod_data_i),
    .prod_pend_i(prod_pend_i),
    .flush_i    (flush_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .op_a_o     (op_a_o),
    .op_b_o     (op_b_o),
    .fw_a_o     (fw_a_o),
    .fw_b_o     (fw_b_o),
    .stall_o    (stall_o)
`ifdef FWD_STATS_EN
    ,
    .fwd_cnt_o  (fwd_cnt_o),
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  typedef struct {
    string       nm;
    logic [4:0]  rs, rt;
    logic [31:0] rs_d, rt_d;
    logic [1:0]  wr, pend;
    logic [4:0]  r0, r1;
    logic [31:0] v0, v1;
    logic [31:0] ea, eb;
    logic [1:0]  fa, fb;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic clr_prod();
    prod_wr_i   = '0;
    prod_pend_i = '0;
    rd0 = '0; rd1 = '0; d0 = '0; d1 = '0;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic st,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] fa, input logic [1:0] fb);
    chk({nm, ".out_valid"}, 32'(out_valid_o), 32'(v));
    chk({nm, ".stall"},     32'(stall_o),     32'(st));
    chk({nm, ".op_a"},      op_a_o,           a);
    chk({nm, ".op_b"},      op_b_o,           b);
    chk({nm, ".fw_a"},      32'(fw_a_o),      32'(fa));
    chk({nm, ".fw_b"},      32'(fw_b_o),      32'(fb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          name        rs  rt  rs_d       rt_d       wr     pend   r0  r1  v0         v1         ea         eb         fa    fb
    vecs[0] = '{"no_match", 3,  4,  32'h11,    32'h22,    2'b00, 2'b00, 0,  0,  32'h0,     32'h0,     32'h11,    32'h22,    2'd0, 2'd0};
    vecs[1] = '{"youngest", 5,  6,  32'h55,    32'h66,    2'b11, 2'b00, 5,  5,  32'hAA,    32'hBB,    32'hAA,    32'h66,    2'd1, 2'd0};
    vecs[2] = '{"addr0",    0,  9,  32'h0,     32'h99,    2'b01, 2'b00, 0,  0,  32'hFF,    32'h0,     32'h0,     32'h99,    2'd0, 2'd0};
    vecs[3] = '{"wr_gate",  8,  8,  32'h8,     32'h8,     2'b10, 2'b00, 8,  8,  32'h777,   32'h123,   32'h123,   32'h123,   2'd2, 2'd2};
    vecs[4] = '{"cross",    1,  2,  32'h1,     32'h2,     2'b11, 2'b00, 2,  1,  32'hD0,    32'hD1,    32'hD1,    32'hD0,    2'd2, 2'd1};
    vecs[5] = '{"hi_addr",  31, 30, 32'h1,     32'h2,     2'b11, 2'b00, 30, 31, 32'hE0,    32'hE1,    32'hE1,    32'hE0,    2'd2, 2'd1};
    vecs[6] = '{"pend_lose",4,  10, 32'h40,    32'hA0,    2'b11, 2'b10, 4,  4,  32'h1111,  32'h2222,  32'h1111,  32'hA0,    2'd1, 2'd0};
    vecs[7] = '{"pend_nowr",12, 13, 32'hC,     32'hD,     2'b00, 2'b11, 12, 13, 32'h5,     32'h6,     32'hC,     32'hD,     2'd0, 2'd0};

    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    rs_addr_i = '0; rt_addr_i = '0; rs_data_i = '0; rt_data_i = '0;
    clr_prod();
    step(); step();
    chk_out("reset", 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 2'd0);
`ifdef FWD_STATS_EN
    chk("reset.fwd_cnt",   fwd_cnt_o,   32'd0);
    chk("reset.stall_cnt", stall_cnt_o, 32'd0);
`endif
    rst_i = 1'b0;
    step();
    chk("idle.in_ready", 32'(in_ready_o), 32'd1);

    // Table: single-cycle resolve from IDLE, then drain back to IDLE.
    foreach (vecs[i]) begin
      rs_addr_i = vecs[i].rs; rt_addr_i = vecs[i].rt;
      rs_data_i = vecs[i].rs_d; rt_data_i = vecs[i].rt_d;
      prod_wr_i = vecs[i].wr; prod_pend_i = vecs[i].pend;
      rd0 = vecs[i].r0; rd1 = vecs[i].r1; d0 = vecs[i].v0; d1 = vecs[i].v1;
      in_valid_i = 1'b1; out_ready_i = 1'b0;
      step();
      in_valid_i = 1'b0;
      clr_prod();
      chk_out(vecs[i].nm, 1'b1, 1'b0, vecs[i].ea, vecs[i].eb, vecs[i].fa, vecs[i].fb);
      out_ready_i = 1'b1;
      step();
      chk({vecs[i].nm, ".drain"}, 32'(out_valid_o), 32'd0);
      out_ready_i = 1'b0;
    end

    // Load hazard on rt: two stall cycles, held rs data survives input changes.
    rs_addr_i = 3; rs_data_i = 32'h33; rt_addr_i = 7; rt_data_i = 32'h77;
    prod_wr_i = 2'b01; rd0 = 7; prod_pend_i = 2'b01; d0 = 32'hBAD;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0; rs_data_i = 32'hDEAD; rt_data_i = 32'h0;
    chk("wait1.stall",     32'(stall_o),     32'd1);
    chk("wait1.out_valid", 32'(out_valid_o), 32'd0);
    chk("wait1.in_ready",  32'(in_ready_o),  32'd0);
    step();
    chk("wait2.stall",     32'(stall_o),     32'd1);
    prod_pend_i = 2'b00; d0 = 32'hCC;
    step();
    clr_prod();
    chk_out("wait_exit", 1'b1, 1'b0, 32'h33, 32'hCC, 2'd0, 2'd1);
    out_ready_i = 1'b1;
    step();
    chk("wait_exit.drain", 32'(out_valid_o), 32'd0);
    out_ready_i = 1'b0;

    // Backpressure for 3 cycles, then handshake with a back-to-back accept.
    rs_addr_i = 3; rs_data_i = 32'h11; rt_addr_i = 4; rt_data_i = 32'h22;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk_out("bp_hold", 1'b1, 1'b0, 32'h11, 32'h22, 2'd0, 2'd0);
      chk("bp_hold.in_ready", 32'(in_ready_o), 32'd0);
      step();
    end
    rs_data_i = 32'h44; rt_data_i = 32'h45; in_valid_i = 1'b1; out_ready_i = 1'b1;
    #1;
    chk("b2b.in_ready", 32'(in_ready_o), 32'd1);
    step();
    in_valid_i = 1'b0;
    chk_out("b2b", 1'b1, 1'b0, 32'h44, 32'h45, 2'd0, 2'd0);
    step();
    chk("b2b.drain", 32'(out_valid_o), 32'd0);
    out_ready_i = 1'b0;

    // Flush overrides an accept from IDLE.
    in_valid_i = 1'b1; flush_i = 1'b1;
    step();
    in_valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_idle.out_valid", 32'(out_valid_o), 32'd0);

    // Flush during WAIT.
    rs_addr_i = 9; rs_data_i = 32'h9; rt_addr_i = 0;
    prod_wr_i = 2'b10; rd1 = 9; prod_pend_i = 2'b10; d1 = 32'h5;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    chk("fl_wait.stall", 32'(stall_o), 32'd1);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    clr_prod();
    chk("fl_wait.out_valid", 32'(out_valid_o), 32'd0);
    chk("fl_wait.stall_off", 32'(stall_o),     32'd0);
    chk("fl_wait.in_ready",  32'(in_ready_o),  32'd1);
`ifdef FWD_STATS_EN
    chk("fl_wait.fwd_cnt",   fwd_cnt_o,   32'd6);
    chk("fl_wait.stall_cnt", stall_cnt_o, 32'd3);
`endif

    // Reset during VALID, with flush and a pending accept also asserted.
    rs_addr_i = 3; rs_data_i = 32'h5A; rt_addr_i = 2; rt_data_i = 32'h5B;
    prod_wr_i = 2'b01; rd0 = 2; d0 = 32'h77;
    in_valid_i = 1'b1;
    step();
    chk_out("pre_rst", 1'b1, 1'b0, 32'h5A, 32'h77, 2'd0, 2'd1);
    rst_i = 1'b1; flush_i = 1'b1; out_ready_i = 1'b1;
    step();
    rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    clr_prod();
    chk_out("rst_valid", 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 2'd0);
`ifdef FWD_STATS_EN
    chk("rst_valid.fwd_cnt",   fwd_cnt_o,   32'd0);
    chk("rst_valid.stall_cnt", stall_cnt_o, 32'd0);
`endif
    step();
    chk("post_rst.out_valid", 32'(out_valid_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
